// File: rtl/vec_issue_queue.sv
// Purpose : FIFO of decoded vector register-group requests feeding the AGU one group at a time.
// Latency : request accepted at edge E can produce agu_en in the cycle after edge E+1 (no bypass).
// Backpressure: in_ready drops when DEPTH entries are held; dispatch waits on agu_idle and leaves a gap cycle.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   flush              synchronous drop of every queued entry (beats push and dispatch)
//   in_valid/in_ready  decode handshake; in_addr / in_vlmul carry the request
//   agu_idle           AGU can take a new group
//   agu_en             one-cycle dispatch pulse; agu_addr / agu_vlmul hold the last dispatched group
//   err_illegal        one-cycle pulse after an illegal request was consumed and dropped
//   count              current occupancy
module vec_issue_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic [2:0]                   in_vlmul,
    input  logic                         agu_idle,
    output logic                         agu_en,
    output logic [ADDR_WIDTH-1:0]        agu_addr,
    output logic [2:0]                   agu_vlmul,
    output logic                         err_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            vlmul;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    logic            handshake;
    logic            illegal;
    logic            push;
    logic            dispatch;
    logic [ADDR_WIDTH-1:0] hi_mask;
    entry_t          in_entry;

    // Full is judged from count alone; a same-cycle pop never reopens the input.
    assign in_ready  = rst & (count != CW'(DEPTH));
    assign handshake = in_valid & in_ready;

    // For an integer LMUL of 2^vlmul the group base is shifted left by vlmul,
    // so the top vlmul address bits must be clear or the group runs off the file.
    assign hi_mask = ~({ADDR_WIDTH{1'b1}} >> in_vlmul[1:0]);

    always_comb begin
        illegal = 1'b0;
        if (in_vlmul == 3'b100) begin
            illegal = 1'b1;
        end else if (!in_vlmul[2]) begin
            illegal = |(in_addr & hi_mask);
        end
    end

    assign push     = handshake & ~illegal & ~flush;
    // ~agu_en enforces a gap cycle: agu_idle only drops a cycle after the enable.
    assign dispatch = (count != '0) & agu_idle & ~agu_en & ~flush;

    assign in_entry.addr  = in_addr;
    assign in_entry.vlmul = in_vlmul;

    // Payload storage carries no reset; only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            agu_en      <= 1'b0;
            agu_addr    <= '0;
            agu_vlmul   <= '0;
            err_illegal <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            agu_en      <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= handshake & illegal;
            agu_en      <= dispatch;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (dispatch) begin
                rd_ptr    <= rd_ptr + PW'(1);
                agu_addr  <= mem[rd_ptr].addr;
                agu_vlmul <= mem[rd_ptr].vlmul;
            end
            count <= count + CW'(push) - CW'(dispatch);
        end
    end

endmodule
